timer_arbiter: RTL and testbench
================================

// Module: timer_arbiter
// PURPOSE
//   Shares one one-shot interval timer among N_REQ requesters.
//   Grants requesters round-robin and issues a one-cycle TMR_START.
//   Waits for the timer's expiry pulse, then returns a one-cycle DONE to the owner.
//   A watchdog flags a timer that never pulses.
// PARAMETERS
//   N_REQ     4          number of requesters (>=2)
//   WDOG_MAX  2500000    WAIT cycles before watchdog timeout (> timer period)
//   WDOG_W    22         watchdog counter width; must hold WDOG_MAX
// PORTS
//   CLK        in   1             clock
//   RST_N      in   1             reset, asynchronous, active-low
//   REQ        in   N_REQ         level requests; held until DONE
//   DONE       out  N_REQ         one-cycle completion pulse to the granted requester
//   GNT_VLD    out  1             a requester currently owns the timer
//   GNT_ID     out  $clog2(N_REQ) index of the owner; valid when GNT_VLD
//   BUSY       out  1             state != IDLE
//   TMR_START  out  1             one-cycle start strobe to the timer
//   TMR_PULSE  in   1             one-cycle expiry pulse from the timer
//   ERR_WDOG   out  1             sticky watchdog error
//   ERR_CLR    in   1             clears ERR_WDOG
// BEHAVIOUR
//   Reset values: DONE=0, GNT_VLD=0, GNT_ID=0, BUSY=0, TMR_START=0, ERR_WDOG=0.
//   Reset values (internal): ptr=N_REQ-1, wdog=0, state=IDLE. All outputs are registered.
//   States: IDLE, WAIT, HOLD. Any other encoding goes to IDLE.
//   IDLE, when REQ!=0:
//     - pick the first set REQ bit searching ptr+1, ptr+2, ... with wrap mod N_REQ.
//     - GNT_ID<=pick, ptr<=pick, GNT_VLD<=1, TMR_START<=1, wdog<=0; go to WAIT.
//   IDLE, when REQ==0: stay in IDLE.
//   TMR_START is high for exactly the first cycle of WAIT.
//   WAIT, each cycle: wdog<=wdog+1.
//     - TMR_PULSE=1 and REQ[GNT_ID]=1: DONE[GNT_ID]<=1; go to HOLD.
//     - TMR_PULSE=1 and REQ[GNT_ID]=0 (owner cancelled): no DONE; go to HOLD.
//     - TMR_PULSE=0 and wdog==WDOG_MAX-1: ERR_WDOG<=1, no DONE; go to HOLD.
//     - TMR_PULSE and timeout in the same cycle: the pulse wins, ERR_WDOG unchanged.
//   Cancellation: the timer cannot be aborted, so a cancelled grant still waits for TMR_PULSE.
//   HOLD (exactly one cycle):
//     - GNT_VLD<=0; go to IDLE.
//     - This cycle lets the owner drop REQ after DONE, before rearbitration.
//   DONE is asserted in the HOLD cycle only, for one cycle.
//   Requester rule: drop REQ on the edge that ends the DONE cycle; REQ is then low in the next IDLE.
//   Latency:
//     - REQ sampled high in IDLE at cycle T -> TMR_START high at T+1.
//     - TMR_PULSE at cycle P -> DONE high at P+1; next grant no earlier than P+2 (IDLE at P+2).
//   TMR_PULSE outside WAIT is ignored. This covers a late pulse after a watchdog timeout.
//   ERR_WDOG: set by a timeout, cleared by ERR_CLR. If both occur in the same cycle, set wins.
//   REQ changes in WAIT or HOLD do not affect ptr; only a grant updates ptr.
//   Reset mid-operation: all state returns to reset values immediately; no DONE is issued.
//   After reset, requester 0 has highest priority.
// TESTING (use WDOG_MAX=16 unless noted)
//   1. REQ=0001, timer pulses 5 cycles after start.
//      -> TMR_START for 1 cycle, then DONE=0001 for 1 cycle; GNT_ID=0; BUSY low 2 cycles after pulse.
//   2. REQ=1111 held, each bit dropped after its DONE, re-raised 1 cycle later.
//      -> grant order 0,1,2,3,0,1.
//   3. Grant requester 2, drop REQ[2] mid-WAIT, pulse 3 cycles later.
//      -> DONE stays 0000; IDLE 2 cycles after the pulse; next grant goes to 3 if requested.
//   4. Grant requester 1, never pulse.
//      -> ERR_WDOG=1 after 16 WAIT cycles; DONE stays 0; a late pulse is ignored; ERR_CLR clears it.
//   5. TMR_PULSE in the same cycle as wdog==15.
//      -> DONE pulses, ERR_WDOG stays 0.
//   6. Assert RST_N low in WAIT with GNT_ID=3, then re-request 1111.
//      -> outputs go to reset values asynchronously; the first grant after reset is 0.

Source files
------------

// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester/timer bundle of timer_arbiter.
// master: REQ, TMR_PULSE, ERR_CLR out; slave: the arbiter.
interface timer_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0] REQ;
  logic [N_REQ-1:0] DONE;
  logic             GNT_VLD;
  logic [IDW-1:0]   GNT_ID;
  logic             BUSY;
  logic             TMR_START;
  logic             TMR_PULSE;
  logic             ERR_WDOG;
  logic             ERR_CLR;

  modport master (
    output REQ, TMR_PULSE, ERR_CLR,
    input  DONE, GNT_VLD, GNT_ID,
    input  BUSY, TMR_START, ERR_WDOG
  );

  modport slave (
    input  REQ, TMR_PULSE, ERR_CLR,
    output DONE, GNT_VLD, GNT_ID,
    output BUSY, TMR_START, ERR_WDOG
  );
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin share of one one-shot timer.
// CLK, RST_N (async low) plus bus: REQ/DONE/GNT/TMR/ERR.
module timer_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WDOG_MAX = 2500000,
  parameter int WDOG_W   = 22
) (
  input  logic           CLK,
  input  logic           RST_N,
  timer_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             err_q, err_d;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic             timeout;

  // Search ptr+1, ptr+2, ... so the last owner goes last.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign timeout = (wdog_q == WDOG_W'(WDOG_MAX - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    wdog_d    = wdog_q;
    done_d    = '0;
    start_d   = 1'b0;
    err_d     = err_q;
    if (bus.ERR_CLR) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d  = pick;
          ptr_d     = pick;
          gnt_vld_d = 1'b1;
          start_d   = 1'b1;
          wdog_d    = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // Pulse beats a same-cycle timeout.
        if (bus.TMR_PULSE) begin
          if (bus.REQ[gnt_id_q])
            done_d[gnt_id_q] = 1'b1;
          state_d = HOLD;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(N_REQ - 1);
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      wdog_q    <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  assign bus.DONE      = done_q;
  assign bus.GNT_VLD   = gnt_vld_q;
  assign bus.GNT_ID    = gnt_id_q;
  assign bus.BUSY      = busy_q;
  assign bus.TMR_START = start_q;
  assign bus.ERR_WDOG  = err_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scenario tasks for timer_arbiter.
// Expected grants queued at stimulus, popped at TMR_START.
module tb_timer_arbiter;
  localparam int N  = 4;
  localparam int WD = 16;

  typedef struct {
    int         id;
    logic [3:0] done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  timer_arbiter_if #(.N_REQ(N)) bus();

  timer_arbiter #(
    .N_REQ(N),
    .WDOG_MAX(WD),
    .WDOG_W(5)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.REQ = '0;
    bus.TMR_PULSE = 1'b0;
    bus.ERR_CLR = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.TMR_START === 1'b1) ok = 1'b1;
    end
  endtask

  // Plays requester and timer for one grant.
  task automatic serve(input int dly, input bit rearm,
                       output int id, output logic [3:0] dn,
                       output bit ok);
    id = -1;
    dn = 'x;
    wait_start(ok);
    if (!ok) return;
    id = int'(bus.GNT_ID);
    repeat (dly) @(negedge clk);
    bus.TMR_PULSE = 1'b1;
    @(negedge clk);
    bus.TMR_PULSE = 1'b0;
    dn = bus.DONE;
    bus.REQ[id[1:0]] = 1'b0;
    @(negedge clk);
    if (rearm) bus.REQ[id[1:0]] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.REQ = '0;
    bus.TMR_PULSE = 1'b0;
    bus.ERR_CLR = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.DONE, bus.GNT_VLD, bus.GNT_ID, bus.BUSY,
         bus.TMR_START, bus.ERR_WDOG} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got %b want 0",
        {bus.DONE, bus.GNT_VLD, bus.GNT_ID, bus.BUSY,
         bus.TMR_START, bus.ERR_WDOG});
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    exp_q.push_back('{0, 4'b0001});
    bus.REQ = 4'b0001;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({bus.TMR_START, bus.GNT_VLD, bus.BUSY} !== 3'b111) begin
      errors++;
      $display("FAIL single_start: got %b want 111",
        {bus.TMR_START, bus.GNT_VLD, bus.BUSY});
    end
    checks++;
    if (int'(bus.GNT_ID) !== e.id) begin
      errors++;
      $display("FAIL single_id: got %0d want %0d",
        bus.GNT_ID, e.id);
    end
    @(negedge clk);
    checks++;
    if (bus.TMR_START !== 1'b0) begin
      errors++;
      $display("FAIL single_start_len: got %b want 0",
        bus.TMR_START);
    end
    repeat (3) @(negedge clk);
    bus.TMR_PULSE = 1'b1;
    @(negedge clk);
    bus.TMR_PULSE = 1'b0;
    checks++;
    if (bus.DONE !== e.done || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got %b/%b want %b/1",
        bus.DONE, bus.BUSY, e.done);
    end
    bus.REQ = '0;
    @(negedge clk);
    checks++;
    if ({bus.DONE, bus.BUSY, bus.GNT_VLD} !== 6'b0) begin
      errors++;
      $display("FAIL single_idle: got %b want 0",
        {bus.DONE, bus.BUSY, bus.GNT_VLD});
    end
  endtask

  task automatic test_back_to_back();
    int ord[6] = '{0, 1, 2, 3, 0, 1};
    int id;
    logic [3:0] dn;
    bit ok;
    exp_t e;
    do_reset();
    foreach (ord[k])
      exp_q.push_back('{ord[k], 4'(1 << ord[k])});
    bus.REQ = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      serve(2, 1'b1, id, dn, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || id !== e.id || dn !== e.done) begin
        errors++;
        $display("FAIL rr_%0d: got ok=%0d id=%0d dn=%b want id=%0d dn=%b",
          k, ok, id, dn, e.id, e.done);
      end
    end
  endtask

  task automatic test_cancel();
    int id;
    logic [3:0] dn;
    logic [3:0] dsum;
    bit ok;
    exp_t e;
    do_reset();
    exp_q.push_back('{2, 4'b0000});
    exp_q.push_back('{3, 4'b1000});
    bus.REQ = 4'b0100;
    wait_start(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || int'(bus.GNT_ID) !== e.id) begin
      errors++;
      $display("FAIL cancel_id: got ok=%0d id=%0d want %0d",
        ok, bus.GNT_ID, e.id);
    end
    @(negedge clk);
    bus.REQ = 4'b1001;
    dsum = bus.DONE;
    repeat (2) begin
      @(negedge clk);
      dsum |= bus.DONE;
    end
    bus.TMR_PULSE = 1'b1;
    @(negedge clk);
    bus.TMR_PULSE = 1'b0;
    dsum |= bus.DONE;
    checks++;
    if (dsum !== e.done || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL cancel_done: got %b/%b want %b/1",
        dsum, bus.BUSY, e.done);
    end
    @(negedge clk);
    checks++;
    if ({bus.BUSY, bus.GNT_VLD, bus.DONE} !== 6'b0) begin
      errors++;
      $display("FAIL cancel_idle: got %b want 0",
        {bus.BUSY, bus.GNT_VLD, bus.DONE});
    end
    serve(2, 1'b0, id, dn, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || id !== e.id || dn !== e.done) begin
      errors++;
      $display("FAIL cancel_next: got ok=%0d id=%0d dn=%b want %0d/%b",
        ok, id, dn, e.id, e.done);
    end
  endtask

  task automatic test_wdog();
    logic [3:0] dsum;
    bit ok;
    exp_t e;
    do_reset();
    exp_q.push_back('{1, 4'b0000});
    bus.REQ = 4'b0010;
    wait_start(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || int'(bus.GNT_ID) !== e.id) begin
      errors++;
      $display("FAIL wdog_id: got ok=%0d id=%0d want %0d",
        ok, bus.GNT_ID, e.id);
    end
    dsum = '0;
    repeat (WD - 1) begin
      @(negedge clk);
      dsum |= bus.DONE;
    end
    checks++;
    if (bus.ERR_WDOG !== 1'b0 || bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL wdog_early: got err=%b busy=%b want 0/1",
        bus.ERR_WDOG, bus.BUSY);
    end
    @(negedge clk);
    dsum |= bus.DONE;
    checks++;
    if (bus.ERR_WDOG !== 1'b1 || dsum !== e.done) begin
      errors++;
      $display("FAIL wdog_set: got err=%b dn=%b want 1/%b",
        bus.ERR_WDOG, dsum, e.done);
    end
    bus.REQ = '0;
    @(negedge clk);
    bus.TMR_PULSE = 1'b1;
    @(negedge clk);
    bus.TMR_PULSE = 1'b0;
    checks++;
    if ({bus.DONE, bus.BUSY, bus.TMR_START, bus.ERR_WDOG}
        !== 7'b0000_001) begin
      errors++;
      $display("FAIL wdog_late: got %b want 0000001",
        {bus.DONE, bus.BUSY, bus.TMR_START, bus.ERR_WDOG});
    end
    bus.ERR_CLR = 1'b1;
    @(negedge clk);
    bus.ERR_CLR = 1'b0;
    checks++;
    if (bus.ERR_WDOG !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clr: got %b want 0", bus.ERR_WDOG);
    end
  endtask

  task automatic test_race();
    int id;
    logic [3:0] dn;
    bit ok;
    exp_t e;
    do_reset();
    exp_q.push_back('{0, 4'b0001});
    bus.REQ = 4'b0001;
    serve(WD - 1, 1'b0, id, dn, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || id !== e.id || dn !== e.done) begin
      errors++;
      $display("FAIL race_done: got ok=%0d id=%0d dn=%b want %0d/%b",
        ok, id, dn, e.id, e.done);
    end
    checks++;
    if (bus.ERR_WDOG !== 1'b0) begin
      errors++;
      $display("FAIL race_err: got %b want 0", bus.ERR_WDOG);
    end
  endtask

  task automatic test_midreset();
    int id;
    logic [3:0] dn;
    bit ok;
    exp_t e;
    do_reset();
    exp_q.push_back('{3, 4'b1000});
    bus.REQ = 4'b1000;
    wait_start(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || int'(bus.GNT_ID) !== e.id) begin
      errors++;
      $display("FAIL midrst_id: got ok=%0d id=%0d want %0d",
        ok, bus.GNT_ID, e.id);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.DONE, bus.GNT_VLD, bus.GNT_ID, bus.BUSY,
         bus.TMR_START, bus.ERR_WDOG} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got %b want 0",
        {bus.DONE, bus.GNT_VLD, bus.GNT_ID, bus.BUSY,
         bus.TMR_START, bus.ERR_WDOG});
    end
    bus.REQ = 4'b1111;
    exp_q.push_back('{0, 4'b0001});
    @(negedge clk);
    rst_n = 1'b1;
    serve(3, 1'b0, id, dn, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || id !== e.id || dn !== e.done) begin
      errors++;
      $display("FAIL midrst_first: got ok=%0d id=%0d dn=%b want %0d/%b",
        ok, id, dn, e.id, e.done);
    end
  endtask

  initial begin
    bus.REQ = '0;
    bus.TMR_PULSE = 1'b0;
    bus.ERR_CLR = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cancel();
    test_wdog();
    test_race();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
